// File: rtl/cdc_hs_tx_ctrl_pkg.sv
// Shared types and constants for the req/ack handshake transmit controller.
package cdc_hs_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    ERR    = 2'd3
  } hs_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/cdc_hs_tx_ctrl_sync.sv
// Multi-stage flop synchronizer for bringing asynchronous levels into i_clk.
module cdc_hs_tx_ctrl_sync
  import cdc_hs_tx_ctrl_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = SYNC_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift the sampled level through the synchronizer chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign o_q = stage_r[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_ctrl.sv
// Source side of a 4-phase req/ack handshake: holds a word on o_data while
// o_req is up, with per-phase timeout, sticky error and a transfer counter.
module cdc_hs_tx_ctrl
  import cdc_hs_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TMO_WIDTH      = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_req,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_timeout,
  input  logic                  i_clr_timeout,
  output logic [CNT_WIDTH-1:0]  o_xfer_cnt
);

  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  hs_state_e            state_r;
  logic                 ack_s;
  logic [TMO_WIDTH-1:0] timer_r;
  logic                 exit_s;
  logic                 tmo_hit_s;

  cdc_hs_tx_ctrl_sync #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_ack),
    .o_q     (ack_s)
  );

  // A new word is only taken once the previous ack has been seen low.
  assign o_ready = (state_r == IDLE) && !ack_s;
  assign o_busy  = (state_r != IDLE);

  // Phase exit condition and timeout detection for the waiting states.
  always_comb begin
    exit_s = 1'b0;
    case (state_r)
      REQ_HI:  exit_s = ack_s;
      REQ_LO:  exit_s = !ack_s;
      default: exit_s = 1'b0;
    endcase
    tmo_hit_s = TMO_EN && (timer_r == TMO_LAST);
  end

  // Handshake sequencer with registered request, data, error and counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= IDLE;
      o_req      <= 1'b0;
      o_data     <= '0;
      o_timeout  <= 1'b0;
      o_xfer_cnt <= '0;
      timer_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid && o_ready) begin
            o_data  <= i_data;
            o_req   <= 1'b1;
            timer_r <= '0;
            state_r <= REQ_HI;
          end
        end
        REQ_HI: begin
          // A late ack still wins over a timeout landing on the same cycle.
          if (exit_s) begin
            o_req   <= 1'b0;
            timer_r <= '0;
            state_r <= REQ_LO;
          end else if (tmo_hit_s) begin
            o_timeout <= 1'b1;
            o_req     <= 1'b0;
            state_r   <= ERR;
          end else begin
            timer_r <= timer_r + TMO_WIDTH'(1);
          end
        end
        REQ_LO: begin
          if (exit_s) begin
            o_xfer_cnt <= o_xfer_cnt + CNT_WIDTH'(1);
            timer_r    <= '0;
            state_r    <= IDLE;
          end else if (tmo_hit_s) begin
            o_timeout <= 1'b1;
            o_req     <= 1'b0;
            state_r   <= ERR;
          end else begin
            timer_r <= timer_r + TMO_WIDTH'(1);
          end
        end
        ERR: begin
          o_req <= 1'b0;
          if (i_clr_timeout && !ack_s) begin
            o_timeout <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          o_req   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx_ctrl.sv
// Randomized bench for cdc_hs_tx_ctrl: a delayed-response destination model,
// arithmetic latency/timeout predictions and an in-order word scoreboard.
module tb_cdc_hs_tx_ctrl;

  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam int TW  = 5;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ack = 1'b0;
  logic          clr = 1'b0;
  logic          ready, req, busy, tmo_flag;
  logic [DW-1:0] q_data;
  logic [CW-1:0] xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  bit            resp_en = 1'b0;
  int            d1 = 0, d2 = 0, wcnt = 0;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] exp_q[$];
  int            exp_cnt = 0;

  cdc_hs_tx_ctrl #(
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO),
    .TMO_WIDTH      (TW),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .i_data        (data),
    .o_ready       (ready),
    .o_req         (req),
    .o_data        (q_data),
    .i_ack         (ack),
    .o_busy        (busy),
    .o_timeout     (tmo_flag),
    .i_clr_timeout (clr),
    .o_xfer_cnt    (xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; the destination model reacts to what it sees after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (resp_en) begin
      if (req && !ack) begin
        if (wcnt >= d1) begin
          ack = 1'b1;
          rx_q.push_back(q_data);
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else if (!req && ack) begin
        if (wcnt >= d2) begin
          ack = 1'b0;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] w, input int dly1, input int dly2, input bit hold);
    int acc, t_req_lo, t_end, exp_end, exp_lo, q;
    bit data_bad, got_tmo, exp_tmo;
    d1 = dly1; d2 = dly2; wcnt = 0; resp_en = 1'b1;
    valid = 1'b1;
    data = w;
    for (int i = 0; i < 60 && !ready; i++) tick();
    acc = cyc;
    tick();
    if (!hold) valid = 1'b0;
    t_req_lo = -1; data_bad = 1'b0; got_tmo = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!req && t_req_lo < 0) t_req_lo = cyc;
      if (q_data !== w) data_bad = 1'b1;
      if (tmo_flag) begin
        got_tmo = 1'b1;
        break;
      end
      if (ready) break;
      data = DW'($urandom);
      tick();
    end
    t_end = cyc;
    if (dly1 > TMO - 3) begin
      exp_tmo = 1'b1; exp_end = acc + 1 + TMO; exp_lo = exp_end;
    end else if (dly2 > TMO - 3) begin
      exp_tmo = 1'b1; exp_lo = acc + 4 + dly1; exp_end = exp_lo + TMO;
    end else begin
      exp_tmo = 1'b0; exp_lo = acc + 4 + dly1; exp_end = acc + 7 + dly1 + dly2;
    end
    if (dly1 <= TMO - 1) exp_q.push_back(w);
    if (!exp_tmo) exp_cnt = (exp_cnt + 1) % (1 << CW);
    check_val("timeout_flag", 32'(got_tmo), 32'(exp_tmo));
    check_val("end_latency", 32'(t_end - acc), 32'(exp_end - acc));
    check_val("req_fall_latency", 32'(t_req_lo - acc), 32'(exp_lo - acc));
    check_val("data_held", 32'(data_bad), 32'd0);
    check_val("busy_at_end", 32'(busy), 32'(exp_tmo));
    check_val("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    if (got_tmo) begin
      check_val("req_low_in_err", 32'(req), 32'd0);
      check_val("ready_low_in_err", 32'(ready), 32'd0);
      q = 0;
      for (int i = 0; i < 100 && q < 3; i++) begin
        tick();
        if (ack) q = 0; else q++;
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_val("clr_timeout", 32'(tmo_flag), 32'd0);
      check_val("clr_ready", 32'(ready), 32'd1);
      check_val("clr_cnt_kept", 32'(xfer_cnt), 32'(exp_cnt));
    end
  endtask

  task automatic compare_scoreboard(input string tag);
    check_val({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      check_val({tag, "_word"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    bit ready_bad;
    #2;
    check_val("rst_req", 32'(req), 32'd0);
    check_val("rst_data", 32'(q_data), 32'd0);
    check_val("rst_timeout", 32'(tmo_flag), 32'd0);
    check_val("rst_cnt", 32'(xfer_cnt), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ready", 32'(ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    send(8'hA5, 3, 3, 1'b0);
    check_val("single_cnt", 32'(xfer_cnt), 32'd1);

    for (int w = 1; w <= 4; w++) send(DW'(w), 0, 0, 1'b1);
    valid = 1'b0;
    check_val("b2b_cnt", 32'(xfer_cnt), 32'd5);
    compare_scoreboard("b2b");

    send(DW'($urandom), 13, 0, 1'b0);
    send(DW'($urandom), 14, 2, 1'b0);
    send(DW'($urandom), 0, 13, 1'b0);
    send(DW'($urandom), 2, 14, 1'b0);
    send(DW'($urandom), 1000, 0, 1'b0);
    compare_scoreboard("bound");

    // Stuck ack while in the error state.
    resp_en = 1'b0;
    valid = 1'b1;
    data = DW'($urandom);
    for (int i = 0; i < 20 && !ready; i++) tick();
    tick();
    valid = 1'b0;
    repeat (20) tick();
    check_val("stuck_tmo_set", 32'(tmo_flag), 32'd1);
    ack = 1'b1;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("stuck_tmo_kept", 32'(tmo_flag), 32'd1);
    check_val("stuck_busy", 32'(busy), 32'd1);
    check_val("stuck_ready", 32'(ready), 32'd0);
    ack = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("stuck_clr_ok", 32'(tmo_flag), 32'd0);
    check_val("stuck_ready_back", 32'(ready), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("idle_clr_noeffect", 32'(xfer_cnt), 32'(exp_cnt));

    // Reset one cycle after o_req rises, with ack already high.
    valid = 1'b1;
    data = DW'($urandom);
    tick();
    valid = 1'b0;
    check_val("pre_rst_req", 32'(req), 32'd1);
    ack = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", 32'(req), 32'd0);
    check_val("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    ready_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ready) ready_bad = 1'b1;
      tick();
    end
    check_val("rst_ack_hold_ready", 32'(ready_bad), 32'd0);
    ack = 1'b0;
    check_val("ack_fall_ready_0", 32'(ready), 32'd0);
    tick();
    check_val("ack_fall_ready_1", 32'(ready), 32'd0);
    tick();
    check_val("ack_fall_ready_2", 32'(ready), 32'd1);

    // Counter wrap with random words and response delays.
    for (int n = 0; n < 17; n++) begin
      send(DW'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'b0);
    end
    check_val("wrap_cnt", 32'(xfer_cnt), 32'd1);
    compare_scoreboard("wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx_ctrl.md
Name: cdc_hs_tx_ctrl

Overview:
- Source-side controller for a 4-phase req/ack handshake that moves a DATA_WIDTH word from the i_clk domain to an asynchronous destination domain.
- Accepts words on a valid/ready interface.
- Holds each word stable on o_data while it drives o_req.
- Brings the asynchronous i_ack into i_clk through an internal 2-flop synchronizer.
- Adds a per-transfer timeout, a sticky error flag and a transfer counter, so software can monitor the link.

Parameters:
- DATA_WIDTH, 8, width of transferred word
- TIMEOUT_CYCLES, 1023, i_clk cycles allowed per handshake phase; 0 disables timeout
- TMO_WIDTH, 10, width of timeout counter; must hold TIMEOUT_CYCLES
- CNT_WIDTH, 16, width of completed-transfer counter

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  source word valid
- i_data  in  DATA_WIDTH  source word
- o_ready  out  1  controller can accept a word this cycle
- o_req  out  1  handshake request to destination; registered, glitch-free
- o_data  out  DATA_WIDTH  held word; stable from o_req rise until ack falls
- i_ack  in  1  destination acknowledge; asynchronous to i_clk
- o_busy  out  1  handshake in progress (state != IDLE)
- o_timeout  out  1  sticky timeout error
- i_clr_timeout  in  1  single-cycle pulse that clears o_timeout
- o_xfer_cnt  out  CNT_WIDTH  completed transfers; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset values:
  - o_req=0, o_data=0, o_timeout=0, o_xfer_cnt=0.
  - State=IDLE, synchronizer flops=0, timer=0.
  - o_busy=0; o_ready=1 during and after reset, since ack_s=0.
- Synchronizer: ack_s is i_ack after 2 i_clk flops, reset 0. ack_s is the only use of i_ack.
- o_ready is combinational and equals (state==IDLE && ack_s==0). o_ready must not depend on i_valid.
- States: IDLE, REQ_HI, REQ_LO, ERR.
- IDLE:
  - On i_valid && o_ready: capture o_data<=i_data, set o_req<=1, clear the timer, go to REQ_HI.
  - o_req is high on the cycle after acceptance.
- REQ_HI:
  - When ack_s==1: set o_req<=0, clear the timer, go to REQ_LO.
- REQ_LO:
  - When ack_s==0: o_xfer_cnt+=1 (wrap), go to IDLE.
  - o_data stays unchanged until this exit.
- Timer:
  - Increments each cycle in REQ_HI and REQ_LO while the exit condition is false.
  - If TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with the exit condition still false: set o_timeout<=1, o_req<=0, go to ERR.
  - The exit condition has priority over the timeout in the same cycle.
- ERR:
  - o_ready=0, o_busy=1, o_req=0.
  - Leave ERR for IDLE only when i_clr_timeout==1 && ack_s==0; o_timeout<=0 on that cycle.
  - i_clr_timeout with ack_s==1 is ignored, and o_timeout stays 1.
  - A timed-out transfer does not increment o_xfer_cnt.
- i_clr_timeout outside ERR: has no effect.
- i_data changing while busy: has no effect on o_data.
- i_valid deasserting while busy: has no effect on the transfer in progress.
- Minimum loop latency, with the destination responding instantly:
  - accept at cycle 0; o_req=1 at cycle 1;
  - ack_s=1 at cycle 3; o_req=0 at cycle 4;
  - ack_s=0 at cycle 6; o_xfer_cnt increments and o_ready=1 at cycle 7.
- Reset mid-operation:
  - All state returns to reset values immediately and o_req drops asynchronously.
  - The destination is required to release i_ack after seeing o_req=0.
  - The controller waits for ack_s==0 before o_ready rises.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'd0, REQ_HI=2'd1, REQ_LO=2'd2, ERR=2'd3);
  - SYNC_STAGES=2.
- One sub-module: the existing 2-stage synchronizer, instantiated with width 1 for i_ack.
- All remaining logic stays flat in cdc_hs_tx_ctrl.

Test Plan:
- Single transfer, responder acks 3 cycles after o_req rise and drops ack 3 cycles after o_req fall, i_data=8'hA5:
  - o_data=8'hA5 throughout the handshake;
  - o_req high, then low once ack_s rises;
  - o_xfer_cnt 0->1;
  - o_ready returns to 1.
- Back-to-back, i_valid held high with i_data 8'h01..8'h04:
  - exactly 4 handshakes, delivered in order;
  - o_ready=0 while busy;
  - o_xfer_cnt=4.
- Timeout, TIMEOUT_CYCLES=16, responder never acks:
  - o_timeout=1 and o_req=0 exactly 16 cycles after REQ_HI entry;
  - o_ready=0;
  - i_clr_timeout pulse returns the controller to IDLE with o_timeout=0 and o_xfer_cnt unchanged.
- Stuck ack in ERR: i_ack held 1 during i_clr_timeout:
  - o_timeout stays 1;
  - after i_ack=0 and 2 cycles, a second clear pulse succeeds.
- Reset asserted 1 cycle after o_req rise, i_ack already 1:
  - o_req=0 and o_xfer_cnt=0 immediately;
  - o_ready=0 until 2 cycles after i_ack falls.
- Counter wrap, CNT_WIDTH=4: 17 transfers -> o_xfer_cnt=1.
